// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit ripple stage processes a nibble per cycle.
// The carry is registered between nibbles; valid/ready handshakes on both sides.

module ripple_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [3:0]         add_s;
  logic               add_co;
  logic               last_nib;

  ripple_add4 u_add (
    .a  (a_q[idx_q*4 +: 4]),
    .b  (b_q[idx_q*4 +: 4]),
    .ci (carry_q),
    .s  (add_s),
    .co (add_co)
  );

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*4 +: 4] = add_s;
        carry_d             = add_co;
        if (last_nib) begin
          cout_d  = add_co;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // NOTE: operand registers are pure datapath, always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  // Reset gates in_ready so the source never sees a ready it cannot use.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases on WIDTH=16, randomized
// handshake traffic on WIDTH=4/16/32 against an arithmetic scoreboard.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid_v, out_ready_v;
  logic [2:0]  in_ready_v, out_valid_v, busy_v, cout_v;
  logic [31:0] a_drv, b_drv;
  logic        cin_drv;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;

  int          sel;
  logic        cur_in_ready, cur_out_valid, cur_busy, cur_cout;
  logic [31:0] cur_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin_drv), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum4), .cout(cout_v[0]), .busy(busy_v[0])
  );

  nibble_serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin_drv), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum16), .cout(cout_v[1]), .busy(busy_v[1])
  );

  nibble_serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_drv), .b(b_drv), .cin(cin_drv), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .sum(sum32), .cout(cout_v[2]), .busy(busy_v[2])
  );

  always_comb begin
    cur_in_ready  = 1'b0;
    cur_out_valid = 1'b0;
    cur_busy      = 1'b0;
    cur_cout      = 1'b0;
    cur_sum       = '0;
    case (sel)
      0: begin
        cur_in_ready = in_ready_v[0]; cur_out_valid = out_valid_v[0];
        cur_busy = busy_v[0]; cur_cout = cout_v[0]; cur_sum = {28'd0, sum4};
      end
      1: begin
        cur_in_ready = in_ready_v[1]; cur_out_valid = out_valid_v[1];
        cur_busy = busy_v[1]; cur_cout = cout_v[1]; cur_sum = {16'd0, sum16};
      end
      default: begin
        cur_in_ready = in_ready_v[2]; cur_out_valid = out_valid_v[2];
        cur_busy = busy_v[2]; cur_cout = cout_v[2]; cur_sum = sum32;
      end
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 16 : 32;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input int bound, output int lat);
    lat = 0;
    while (!cur_out_valid && lat < bound) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    sel = 1;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (cur_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b want=0", cur_in_ready);
    end
    checks++;
    if ({cur_out_valid, cur_busy, cur_cout} !== 3'b000 || cur_sum !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got ov=%b busy=%b cout=%b sum=%h want 0 0 0 0",
               cur_out_valid, cur_busy, cur_cout, cur_sum);
    end
    rst = 1'b0;
    step();
    checks++;
    if (cur_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready got=%b want=1", cur_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta[3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
    logic [15:0] tb[3] = '{16'h4321, 16'h0001, 16'hFFFF};
    logic        tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es[3] = '{16'h5555, 16'h0000, 16'hFFFF};
    logic        ec[3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    sel = 1;
    out_ready_v[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_drv = {16'd0, ta[i]}; b_drv = {16'd0, tb[i]}; cin_drv = tc[i];
      in_valid_v[1] = 1'b1;
      step();
      in_valid_v[1] = 1'b0;
      a_drv = $urandom; b_drv = $urandom; cin_drv = 1'b1;
      wait_out_valid(20, lat);
      checks++;
      if (lat !== 4) begin
        errors++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat);
      end
      checks++;
      if (cur_sum[15:0] !== es[i] || cur_cout !== ec[i] || cur_busy !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_result got sum=%h cout=%b busy=%b want sum=%h cout=%b busy=1",
                 i, cur_sum[15:0], cur_cout, cur_busy, es[i], ec[i]);
      end
      step();
      checks++;
      if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_return got ov=%b ir=%b want ov=0 ir=1", i, cur_out_valid, cur_in_ready);
      end
    end
    out_ready_v[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] held_sum;
    logic        held_cout;
    logic [16:0] exp2;
    sel = 1;
    out_ready_v[1] = 1'b0;
    a_drv = 32'h0000_ABCD; b_drv = 32'h0000_1111; cin_drv = 1'b1;
    in_valid_v[1] = 1'b1;
    step();
    in_valid_v[1] = 1'b0;
    wait_out_valid(20, lat);
    held_sum  = cur_sum[15:0];
    held_cout = cur_cout;
    checks++;
    if (held_sum !== 16'hBCDF || held_cout !== 1'b0) begin
      errors++; $display("FAIL bp_first got sum=%h cout=%b want sum=bcdf cout=0", held_sum, held_cout);
    end
    a_drv = 32'h0000_8765; b_drv = 32'h0000_9ABC; cin_drv = 1'b0;
    in_valid_v[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (cur_sum[15:0] !== held_sum || cur_cout !== held_cout ||
          cur_in_ready !== 1'b0 || cur_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%h cout=%b ir=%b ov=%b want sum=%h cout=%b ir=0 ov=1",
                 i, cur_sum[15:0], cur_cout, cur_in_ready, cur_out_valid, held_sum, held_cout);
      end
    end
    out_ready_v[1] = 1'b1;
    step();
    checks++;
    if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", cur_in_ready, cur_out_valid);
    end
    step();
    in_valid_v[1] = 1'b0;
    wait_out_valid(20, lat);
    exp2 = 17'h08765 + 17'h09ABC;
    checks++;
    if (lat !== 4 || {cur_cout, cur_sum[15:0]} !== exp2) begin
      errors++;
      $display("FAIL bp_second got lat=%0d cout,sum=%h want lat=4 cout,sum=%h",
               lat, {cur_cout, cur_sum[15:0]}, exp2);
    end
    step();
    out_ready_v[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen_ov = 0;
    sel = 1;
    out_ready_v[1] = 1'b1;
    a_drv = 32'h0000_FFFF; b_drv = 32'h0000_FFFF; cin_drv = 1'b1;
    in_valid_v[1] = 1'b1;
    step();
    in_valid_v[1] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (cur_sum !== 32'd0 || cur_cout !== 1'b0 || cur_out_valid !== 1'b0 ||
        cur_in_ready !== 1'b1 || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got sum=%h cout=%b ov=%b ir=%b busy=%b want 0 0 0 1 0",
               cur_sum, cur_cout, cur_out_valid, cur_in_ready, cur_busy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (cur_out_valid) seen_ov++;
    end
    checks++;
    if (seen_ov !== 0) begin
      errors++; $display("FAIL rst_mid_no_pulse got=%0d out_valid cycles want=0", seen_ov);
    end
    out_ready_v[1] = 1'b0;
  endtask

  task automatic test_random(input int s, input int n_ops);
    int                w    = width_of(s);
    int                nib  = w / 4;
    longint unsigned   mask = (64'd1 << w) - 1;
    longint unsigned   exp_q[$];
    int                acc_q[$];
    longint unsigned   got;
    bit                pending = 1'b0;
    bit                prev_ov = 1'b0;
    int                cyc = 0;
    int                done = 0;
    sel = s;
    #1;
    while (done < n_ops && cyc < n_ops * 40) begin
      if (!pending && $urandom_range(0, 2) != 0) begin
        a_drv   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b_drv   = $urandom;
        cin_drv = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_valid_v[s]  = pending;
      out_ready_v[s] = ($urandom_range(0, 3) != 0);
      if (cur_out_valid && !prev_ov) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++; $display("FAIL rand_w%0d_spurious_valid at cycle %0d want none", w, cyc);
        end else if (cyc - acc_q[0] != nib) begin
          errors++; $display("FAIL rand_w%0d_latency got=%0d want=%0d", w, cyc - acc_q[0], nib);
        end
      end
      prev_ov = cur_out_valid;
      if (cur_out_valid && out_ready_v[s] && exp_q.size() > 0) begin
        got = (longint'(cur_cout) << w) | (longint'(cur_sum) & mask);
        checks++;
        if (got !== exp_q[0]) begin
          errors++; $display("FAIL rand_w%0d_result op%0d got=%h want=%h", w, done, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        done++;
      end
      if (pending && cur_in_ready) begin
        exp_q.push_back((longint'(a_drv) & mask) + (longint'(b_drv) & mask) + longint'(cin_drv));
        acc_q.push_back(cyc + 1);
        pending = 1'b0;
      end
      step();
      cyc++;
      if (!pending) begin
        a_drv = $urandom; b_drv = $urandom; cin_drv = 1'($urandom_range(0, 1));
      end
    end
    in_valid_v[s]  = 1'b0;
    out_ready_v[s] = 1'b0;
    checks++;
    if (done != n_ops) begin
      errors++; $display("FAIL rand_w%0d_timeout got=%0d completed want=%0d", w, done, n_ops);
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    a_drv = '0;
    b_drv = '0;
    cin_drv = 1'b0;
    sel = 1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(1, 500);
    test_random(0, 500);
    test_random(2, 500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
